// File: rtl/timer_host.sv
// Bus initiator for the countdown timer: programs count and start bit, then
// measures the cycles until the interrupt and returns one response per command.
module timer_host #(
    parameter int TIMEOUT = 1023,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_cnt,
    output logic [7:0]    addr,
    output logic          rw,
    output logic [7:0]    din,
    input  logic          intr,
    output logic          rsp_valid,
    output logic [CW-1:0] rsp_cycles,
    output logic          rsp_timeout,
    output logic          rsp_err,
    output logic          stray_intr
);

    typedef enum logic [2:0] {IDLE, WR_CNT, WR_CTRL, WAIT, RESP} state_t;

    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt_q;
    logic [CW-1:0] lat_q;
    logic [CW-1:0] lat_inc;
    logic          handshake;
    logic          expired;

    // lat_inc already includes the current WAIT cycle
    assign lat_inc   = lat_q + CW'(1);
    assign handshake = (state == IDLE) && cmd_valid;
    assign expired   = (lat_inc == TIMEOUT_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus and handshake outputs decode from state only, so no input reaches them
    always_comb begin
        state_nxt = state;
        addr      = 8'hFF;
        rw        = 1'b0;
        din       = 8'h00;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (cmd_cnt != 8'd0) ? WR_CNT : RESP;
                end
            end
            WR_CNT: begin
                addr      = 8'h04;
                rw        = 1'b1;
                din       = cnt_q;
                state_nxt = WR_CTRL;
            end
            WR_CTRL: begin
                addr      = 8'h00;
                rw        = 1'b1;
                din       = 8'h01;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (intr || expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 8'd0;
            lat_q       <= '0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
            stray_intr  <= 1'b0;
        end else begin
            if (handshake) begin
                cnt_q <= cmd_cnt;
            end
            if (handshake && (cmd_cnt == 8'd0)) begin
                rsp_cycles  <= '0;
                rsp_timeout <= 1'b0;
                rsp_err     <= 1'b1;
            end

            if (state == WR_CTRL) begin
                lat_q <= '0;
            end else if (state == WAIT) begin
                lat_q <= lat_inc;
            end

            // intr wins over the timeout when both land on the same cycle
            if (state == WAIT) begin
                if (intr) begin
                    rsp_cycles  <= lat_inc;
                    rsp_timeout <= 1'b0;
                    rsp_err     <= 1'b0;
                end else if (expired) begin
                    rsp_cycles  <= TIMEOUT_V;
                    rsp_timeout <= 1'b1;
                    rsp_err     <= 1'b0;
                end
            end

            if (intr && (state != WAIT)) begin
                stray_intr <= 1'b1;
            end else if (handshake) begin
                stray_intr <= 1'b0;
            end
        end
    end

endmodule
